// File: rtl/fpga_robots_game_defs.sv
// fpga_robots_game_defs: shared state encodings and serial framing constants
package fpga_robots_game_defs;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam int SER_DATA_BITS = 8;
  localparam logic SER_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/fpga_robots_game_rr_arb2.sv
// fpga_robots_game_rr_arb2: combinational two-port round-robin arbiter
//   valid0/valid1 requests, last_grant previous winner, en allows a grant
//   grant one-hot winner, grant_idx winner index
module fpga_robots_game_rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_idx
);
  assign grant[0] = en & valid0 & (~valid1 | last_grant);
  assign grant[1] = en & valid1 & (~valid0 | ~last_grant);
  assign grant_idx = grant[1];
endmodule

// File: rtl/fpga_robots_game_serial_tx_sched.sv
// fpga_robots_game_serial_tx_sched: two-port round-robin 8N1/8N2 serial transmitter
//   clk/rst_n clock and async active-low reset, baud1 bit-period strobe
//   reqN_valid/reqN_data/reqN_ready byte sources, txd serial line
//   busy frame pending/active, grant_id owner of current/last frame
//   cts flow control input exists only with FPGA_ROBOTS_GAME_TX_FLOWCTL_EN
module fpga_robots_game_serial_tx_sched
  import fpga_robots_game_defs::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud1,
`ifdef FPGA_ROBOTS_GAME_TX_FLOWCTL_EN
  input  logic       cts,
`endif
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       txd,
  output logic       busy,
  output logic       grant_id
);
  logic [2:0] state;
  logic [SER_DATA_BITS-1:0] shreg;
  logic [2:0] bit_cnt;
  logic stop_cnt;
  logic last_grant;
  logic cts_ok;
  logic stop_end;
  logic arb_en;
  logic [1:0] gnt;
  logic gidx;
  logic acc;
`ifdef FPGA_ROBOTS_GAME_TX_FLOWCTL_EN
  logic [1:0] cts_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cts_sync <= 2'b00;
    else cts_sync <= {cts_sync[0], cts};
  assign cts_ok = cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif
  // a new byte may be taken in IDLE or on the strobe closing the last stop bit
  assign stop_end = (state == ST_STOP) & baud1 & (stop_cnt == 1'(STOP_BITS - 1));
  assign arb_en = cts_ok & ((state == ST_IDLE) | stop_end);
  fpga_robots_game_rr_arb2 u_arb (
    .valid0(req0_valid),
    .valid1(req1_valid),
    .last_grant(last_grant),
    .en(arb_en),
    .grant(gnt),
    .grant_idx(gidx)
  );
  assign acc = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign busy = state != ST_IDLE;
  assign grant_id = last_grant;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      shreg <= '0;
      bit_cnt <= 3'd0;
      stop_cnt <= 1'b0;
      last_grant <= 1'b1;
      txd <= SER_IDLE_LEVEL;
    end else begin
      if (acc) begin
        shreg <= gidx ? req1_data : req0_data;
        last_grant <= gidx;
      end
      case (state)
        ST_IDLE: state <= acc ? ST_ALIGN : ST_IDLE;
        ST_ALIGN:
          if (baud1) begin
            txd <= 1'b0;
            state <= ST_START;
          end
        ST_START:
          if (baud1) begin
            txd <= shreg[0];
            shreg <= shreg >> 1;
            bit_cnt <= 3'd0;
            state <= ST_DATA;
          end
        ST_DATA:
          if (baud1) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(SER_DATA_BITS - 1)) begin
              txd <= SER_IDLE_LEVEL;
              stop_cnt <= 1'b0;
              state <= ST_STOP;
            end else begin
              txd <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        ST_STOP:
          if (baud1) begin
            stop_cnt <= stop_cnt + 1'b1;
            // back-to-back frame: the closing stop strobe doubles as the next start edge
            if (stop_end) begin
              txd <= acc ? 1'b0 : SER_IDLE_LEVEL;
              state <= acc ? ST_START : ST_IDLE;
            end
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fpga_robots_game_serial_tx_sched.sv
// tb_fpga_robots_game_serial_tx_sched: directed self-checking bench for the serial tx scheduler
module tb_fpga_robots_game_serial_tx_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] bc = 4'd0;
  logic baud1;
  int bcnt = 0;
  logic v0, v1, v2, cts;
  logic [7:0] d0, d1, d2;
  logic r0, r1, r2a, r2b;
  logic txd, busy, gid, txd2, busy2, gid2;
  int rc0 = 0, rc1 = 0;
  logic [7:0] acc[$];
  int errs = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) bc <= bc + 4'd1;
  assign baud1 = (bc == 4'd15);
  always @(posedge clk) if (baud1) bcnt <= bcnt + 1;

  always @(negedge clk) begin
    if (r0) begin rc0 <= rc0 + 1; acc.push_back(d0); end
    if (r1) begin rc1 <= rc1 + 1; acc.push_back(d1); end
  end

  fpga_robots_game_serial_tx_sched u_dut (
    .clk(clk), .rst_n(rst_n), .baud1(baud1),
`ifdef FPGA_ROBOTS_GAME_TX_FLOWCTL_EN
    .cts(cts),
`endif
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .txd(txd), .busy(busy), .grant_id(gid)
  );

  fpga_robots_game_serial_tx_sched #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .baud1(baud1),
`ifdef FPGA_ROBOTS_GAME_TX_FLOWCTL_EN
    .cts(cts),
`endif
    .req0_valid(v2), .req0_data(d2), .req0_ready(r2a),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(r2b),
    .txd(txd2), .busy(busy2), .grant_id(gid2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_baud();
    do @(negedge clk); while (!baud1);
  endtask

  // samples each bit period on its closing strobe; t0 is the strobe count at the start bit
  task automatic get_frame(input bit w, input int ns, output logic [7:0] d, output int t0);
    bit found;
    found = 1'b0;
    d = 8'hxx;
    t0 = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      wait_baud();
      if ((w ? txd2 : txd) == 1'b0) begin found = 1'b1; t0 = bcnt; end
    end
    chk("start_bit_found", 32'(found), 1);
    if (found) begin
      for (int i = 0; i < 8; i++) begin wait_baud(); d[i] = w ? txd2 : txd; end
      for (int i = 0; i < ns; i++) begin wait_baud(); chk("stop_bit", 32'(w ? txd2 : txd), 1); end
    end
  endtask

  task automatic send(input bit p, input logic [7:0] d);
    bit ok;
    @(posedge clk); #1;
    if (p) begin v1 = 1'b1; d1 = d; end else begin v0 = 1'b1; d0 = d; end
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin @(negedge clk); ok = p ? r1 : r0; end
    chk("ready_seen", 32'(ok), 1);
    @(posedge clk); #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  typedef struct {bit port; logic [7:0] data; bit gid;} vec_t;
  vec_t tbl[5];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int t[4];
    int b0, b1, k;
    logic [7:0] bb[4];
    bit bad, ok;
    tbl[0] = '{0, 8'h55, 0};
    tbl[1] = '{1, 8'h3C, 1};
    tbl[2] = '{1, 8'h81, 1};
    tbl[3] = '{0, 8'hFF, 0};
    tbl[4] = '{0, 8'h00, 0};
    bb = '{8'hA0, 8'h0B, 8'hA0, 8'h0B};
    v0 = 0; v1 = 0; v2 = 0; d0 = 0; d1 = 0; d2 = 0; cts = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready0", 32'(r0), 0);
    chk("rst_ready1", 32'(r1), 0);
    chk("rst_grant_id", 32'(gid), 1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      b0 = rc0; b1 = rc1;
      send(tbl[i].port, tbl[i].data);
      get_frame(0, 1, d, k);
      chk("frame_data", 32'(d), 32'(tbl[i].data));
      chk("busy_at_stop_end", 32'(busy), 1);
      @(negedge clk);
      chk("busy_after", 32'(busy), 0);
      chk("txd_idle", 32'(txd), 1);
      chk("ready0_pulses", 32'(rc0 - b0), tbl[i].port ? 0 : 1);
      chk("ready1_pulses", 32'(rc1 - b1), tbl[i].port ? 1 : 0);
      chk("grant_id", 32'(gid), 32'(tbl[i].gid));
    end

    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    acc.delete();
    v0 = 1; d0 = 8'hA0; v1 = 1; d1 = 8'h0B;
    for (int i = 0; i < 4; i++) begin
      get_frame(0, 1, d, t[i]);
      chk("b2b_data", 32'(d), 32'(bb[i]));
      if (i > 0) chk("b2b_spacing", 32'(t[i] - t[i-1]), 10);
      if (i == 2) begin @(posedge clk); #1 v0 = 0; v1 = 0; end
    end
    @(negedge clk);
    chk("b2b_busy_after", 32'(busy), 0);
    chk("b2b_accepts", 32'(acc.size()), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++) chk("b2b_accept_order", 32'(acc[i]), 32'(bb[i]));

    @(posedge clk); #1 v2 = 1; d2 = 8'hFF;
    get_frame(1, 2, d, t[0]);
    chk("sb2_data0", 32'(d), 32'hFF);
    @(posedge clk); #1 v2 = 0;
    get_frame(1, 2, d, t[1]);
    chk("sb2_data1", 32'(d), 32'hFF);
    chk("sb2_spacing", 32'(t[1] - t[0]), 11);
    @(negedge clk);
    chk("sb2_busy_after", 32'(busy2), 0);

    send(0, 8'h00);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin wait_baud(); ok = (txd == 1'b0); end
    chk("rst_mid_start", 32'(ok), 1);
    repeat (4) wait_baud();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", 32'(txd), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_mid_grant_id", 32'(gid), 1);
    send(1, 8'h96);
    get_frame(0, 1, d, k);
    chk("post_rst_data", 32'(d), 32'h96);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    do begin @(posedge clk); #1; end while (!baud1);
    v0 = 1; d0 = 8'h69; k = bcnt;
    @(negedge clk);
    chk("coincident_ready", 32'(r0), 1);
    @(posedge clk); #1 v0 = 0;
    get_frame(0, 1, d, t[0]);
    chk("coincident_start_delay", 32'(t[0] - k), 2);
    chk("coincident_data", 32'(d), 32'h69);
    @(negedge clk);

`ifdef FPGA_ROBOTS_GAME_TX_FLOWCTL_EN
    @(posedge clk); #1 cts = 0;
    repeat (3) @(posedge clk);
    #1 v1 = 1; d1 = 8'h3C; b1 = rc1; bad = 0;
    repeat (24) begin @(negedge clk); if (r1 || txd !== 1'b1) bad = 1; end
    chk("cts_hold", 32'(bad), 0);
    chk("cts_hold_no_accept", 32'(rc1 - b1), 0);
    @(posedge clk); #1 cts = 1;
    ok = 0;
    for (int i = 0; i < 3 && !ok; i++) begin @(negedge clk); ok = r1; end
    chk("cts_accept", 32'(ok), 1);
    @(posedge clk); #1 v1 = 0; cts = 0;
    get_frame(0, 1, d, k);
    chk("cts_frame_data", 32'(d), 32'h3C);
    cts = 1;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fpga_robots_game_serial_tx_sched.md
# fpga_robots_game_serial_tx_sched

Shared serial transmit scheduler: arbitrates between two byte sources (game-state reporter on port 0, debug/console on port 1) and serializes the granted byte as 8N1/8N2 on a single `txd` line. Bit timing comes from the `baud1` pulse of the clock block (115,200 baud at 65 MHz). Sits between the game logic and the board's serial TX pin.

## Interface
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk` input 1: system clock (65 MHz game clock).
- `rst_n` input 1: asynchronous active-low reset.
- `baud1` input 1: single-cycle bit-period pulse, synchronous to `clk`.
- `req0_valid` input 1: port 0 has a byte.
- `req0_data` input 8: port 0 byte; sampled when `req0_ready` is 1.
- `req0_ready` output 1: port 0 byte accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as port 0, for port 1.
- `cts` input 1: clear-to-send, active high; present only with `FPGA_ROBOTS_GAME_TX_FLOWCTL_EN`.
- `txd` output 1: serial line, idle high.
- `busy` output 1: frame pending or in progress.
- `grant_id` output 1: port owning the current or last frame.

## Operation
- States: IDLE, ALIGN, START, DATA, STOP.
- IDLE: on any valid, grant one port, latch its byte into the shift register, pulse that port's ready for one cycle, go to ALIGN. Port not granted sees ready=0.
- ALIGN: on `baud1`, drive `txd`=0 and go to START.
- START: on `baud1`, drive data bit 0 and go to DATA, bit counter=0.
- DATA: on each `baud1`, shift LSB-first; after bit 7 has lasted one period, drive `txd`=1 and go to STOP.
- STOP: lasts `STOP_BITS` `baud1` periods. On the `baud1` ending the last stop bit:
  - if a request is eligible, accept it (ready pulse), drive `txd`=0, and go to START, giving back-to-back frames with no idle gap;
  - otherwise go to IDLE.
- Arbitration is round-robin with a 1-bit `last_grant`:
  - a single valid port wins;
  - if both are valid, the port ≠ `last_grant` wins;
  - `last_grant` updates on every accept.
- `valid` may drop without acceptance; no byte is taken unless ready=1.
- `baud1` arriving in the same cycle as an accept in IDLE is ignored; the start bit waits for the next `baud1`.
- `busy` = (state ≠ IDLE).
- `grant_id` = `last_grant`.
- Reset values: `txd`=1, `busy`=0, `req0_ready`=`req1_ready`=0, `grant_id`=1 (so port 0 wins first contention), state=IDLE. Reset mid-frame aborts the frame immediately; `txd` returns high asynchronously.

## Timing
- `ready` is combinational from state, `valid`, `last_grant` and (in STOP) `baud1`; there is no path from `data` to `ready`.
- Accept to start-bit edge: 1 cycle to enter ALIGN, then at the next `baud1`.
- Frame length: (10 + `STOP_BITS` − 1) `baud1` periods, measured start edge to start edge when back-to-back.
- `txd` is registered and changes only in the cycle after a `baud1` is sampled. The exceptions are reset, and IDLE to ALIGN, which leaves `txd`=1.
- Throughput: one byte per frame across both ports; with both ports saturated, they alternate strictly.

## Configuration
- `FPGA_ROBOTS_GAME_TX_FLOWCTL_EN` defined:
  - `cts` port exists, synchronized by a 2-flop synchronizer;
  - a new byte is accepted only when synchronized `cts`=1;
  - an in-progress frame always completes regardless of `cts`.
- Not defined: no `cts` port; acceptance ignores flow control.

## Structure
- Shared package/include `fpga_robots_game_defs` holds:
  - state encodings (3-bit: IDLE=0, ALIGN=1, START=2, DATA=3, STOP=4);
  - `SER_DATA_BITS`=8;
  - `SER_IDLE_LEVEL`=1.
- One sub-module: `fpga_robots_game_rr_arb2`.
  - Inputs: two valids, `last_grant`, enable.
  - Outputs: grant one-hot, grant index.
  - Purely combinational.
- The FSM, shift register, bit counter and stop counter live in the top module.

## Test plan
- Bench drives `baud1` every 16 cycles.
- Port 0 sends 0x55 → `req0_ready` pulses once. `txd` per period: 0,1,0,1,0,1,0,1,0,1, then idle high; `busy` falls on the `baud1` ending the stop bit.
- Both ports valid from reset with 0xA0 and 0x0B, held valid → order 0xA0, 0x0B, 0xA0, 0x0B; frames back-to-back with start edges exactly 10 periods apart.
- `STOP_BITS`=2, single byte 0xFF → start low for one period, then high for 10 periods; frame spacing is 11 periods when repeated.
- Reset asserted on the 4th data bit of byte 0x00 → `txd`=1 within the reset cycle and `busy`=0. After release, the next request starts a clean frame and `grant_id` resets to 1.
- With `FPGA_ROBOTS_GAME_TX_FLOWCTL_EN`:
  - `cts`=0 and port 1 valid with 0x3C → no ready and `txd` stays high;
  - `cts` set to 1 → accept within 3 cycles, then normal frame;
  - `cts` dropped mid-frame → frame completes.
- `valid` pulsed for one cycle coinciding with `baud1` in IDLE → byte accepted; start bit appears at the following `baud1`, not the coincident one.
